// File: rtl/hack_soc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hack_soc_pkg
// Description : Shared definitions for the hack SoC ROM service blocks:
//               program-ROM address width and the state encoding of the
//               ROM serial dumper FSM.
//               Optional feature macro: ROM_DUMP_CHECKSUM_EN adds the
//               checksum-byte states to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_soc_pkg;

  // Program ROM holds 2**ROM_ADDR_WIDTH 16-bit words.
  localparam int ROM_ADDR_WIDTH = 15;

  localparam int DUMP_STATE_WIDTH = 4;

  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_IDLE    = 4'd0;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_READ    = 4'd1;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_LATCH   = 4'd2;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_SEND_HI = 4'd3;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_ACK_HI  = 4'd4;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_WAIT_HI = 4'd5;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_SEND_LO = 4'd6;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_ACK_LO  = 4'd7;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_WAIT_LO = 4'd8;
`ifdef ROM_DUMP_CHECKSUM_EN
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_SEND_CK = 4'd9;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_ACK_CK  = 4'd10;
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_WAIT_CK = 4'd11;
`endif
  localparam logic [DUMP_STATE_WIDTH-1:0] ENC_FINISH  = 4'd12;

  typedef enum logic [DUMP_STATE_WIDTH-1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_READ    = ENC_READ,
    ST_LATCH   = ENC_LATCH,
    ST_SEND_HI = ENC_SEND_HI,
    ST_ACK_HI  = ENC_ACK_HI,
    ST_WAIT_HI = ENC_WAIT_HI,
    ST_SEND_LO = ENC_SEND_LO,
    ST_ACK_LO  = ENC_ACK_LO,
    ST_WAIT_LO = ENC_WAIT_LO,
`ifdef ROM_DUMP_CHECKSUM_EN
    ST_SEND_CK = ENC_SEND_CK,
    ST_ACK_CK  = ENC_ACK_CK,
    ST_WAIT_CK = ENC_WAIT_CK,
`endif
    ST_FINISH  = ENC_FINISH
  } dump_state_t;

endpackage : hack_soc_pkg
`default_nettype wire

// File: rtl/rom_serial_dumper.sv
`default_nettype none
// ============================================================================
// Module      : rom_serial_dumper
// Description : Reads a span of program-ROM words and streams them to the
//               host through the UART transmit handshake, two bytes per word,
//               high byte first. Readback counterpart of the serial loader.
//               Optional feature macro: ROM_DUMP_CHECKSUM_EN - append one byte
//               equal to the XOR of all data bytes sent (not sent for an
//               empty dump).
// Ports       : clk, rst (sync, active-high)
//               start/start_addr/word_count : dump request (sampled in IDLE)
//               busy, done                  : status (done = 1-cycle pulse)
//               rom_addr, rom_rd, rom_data  : ROM read port (1-cycle latency)
//               uart_transmit, uart_tx_byte,
//               uart_is_transmitting        : UART transmit port
// Revision    : 1.0 - initial release
// ============================================================================
module rom_serial_dumper
  import hack_soc_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

  dump_state_t           state;
  dump_state_t           next_state;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] word;
  logic                  rd_pending;
  logic [7:0]            send_byte;
  logic                  sending;
`ifdef ROM_DUMP_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    send_byte  = 8'h00;
    sending    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (word_count == '0) ? ST_FINISH : ST_READ;
        end
      end

      ST_READ: next_state = ST_LATCH;

      // The first LATCH cycle captures the word; any extra cycles only wait
      // for a UART still busy with a byte from before a reset.
      ST_LATCH: begin
        if (!uart_is_transmitting) begin
          next_state = ST_SEND_HI;
        end
      end

      ST_SEND_HI: begin
        sending    = 1'b1;
        send_byte  = word[DATA_WIDTH-1 -: 8];
        next_state = ST_ACK_HI;
      end

      ST_ACK_HI: begin
        if (uart_is_transmitting) begin
          next_state = ST_WAIT_HI;
        end
      end

      ST_WAIT_HI: begin
        if (!uart_is_transmitting) begin
          next_state = ST_SEND_LO;
        end
      end

      ST_SEND_LO: begin
        sending    = 1'b1;
        send_byte  = word[7:0];
        next_state = ST_ACK_LO;
      end

      ST_ACK_LO: begin
        if (uart_is_transmitting) begin
          next_state = ST_WAIT_LO;
        end
      end

      ST_WAIT_LO: begin
        if (!uart_is_transmitting) begin
          if (count != COUNT_ONE) begin
            next_state = ST_READ;
          end else begin
`ifdef ROM_DUMP_CHECKSUM_EN
            next_state = ST_SEND_CK;
`else
            next_state = ST_FINISH;
`endif
          end
        end
      end

`ifdef ROM_DUMP_CHECKSUM_EN
      ST_SEND_CK: begin
        sending    = 1'b1;
        send_byte  = checksum;
        next_state = ST_ACK_CK;
      end

      ST_ACK_CK: begin
        if (uart_is_transmitting) begin
          next_state = ST_WAIT_CK;
        end
      end

      ST_WAIT_CK: begin
        if (!uart_is_transmitting) begin
          next_state = ST_FINISH;
        end
      end
`endif

      ST_FINISH: next_state = ST_IDLE;

      default: next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, remaining count, captured word, checksum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      count      <= '0;
      word       <= '0;
      rd_pending <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
      checksum   <= 8'h00;
`endif
    end else begin
      // ROM data arrives exactly one cycle after the read strobe.
      rd_pending <= (state == ST_READ);
      if (rd_pending) begin
        word <= rom_data;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr  <= start_addr;
            count <= word_count;
`ifdef ROM_DUMP_CHECKSUM_EN
            checksum <= 8'h00;
`endif
          end
        end

        ST_WAIT_LO: begin
          if (!uart_is_transmitting) begin
            addr  <= addr + ADDR_ONE;  // wraps modulo 2**ADDR_WIDTH
            count <= count - COUNT_ONE;
          end
        end

`ifdef ROM_DUMP_CHECKSUM_EN
        ST_SEND_HI, ST_SEND_LO: begin
          checksum <= checksum ^ send_byte;
        end
`endif

        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Status and transmit are gated by rst so an abort takes effect in
  // the same cycle it is asserted.
  // --------------------------------------------------------------------------
  assign rom_addr      = addr;
  assign rom_rd        = (state == ST_READ);
  assign uart_transmit = sending && !rst;
  assign uart_tx_byte  = send_byte;
  assign busy          = !rst && (state != ST_IDLE) && (state != ST_FINISH);
  assign done          = !rst && (state == ST_FINISH);

endmodule : rom_serial_dumper
`default_nettype wire

// File: tb/tb_rom_serial_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_serial_dumper
// Description : Scoreboard bench for rom_serial_dumper. A ROM array and a
//               UART responder with random busy time surround the DUT; each
//               issued dump pushes its expected byte stream and ROM addresses
//               into queues that independent monitors pop and compare.
//               Honours ROM_DUMP_CHECKSUM_EN for the expected stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_serial_dumper;

  localparam int AW    = 15;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [15:0]   rom_data = 16'h0000;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting = 1'b0;

  logic [15:0]   rom [0:DEPTH-1];
  int            uart_busy_cnt = 0;

  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addrs[$];
  int            tx_seen   = 0;
  int            done_seen = 0;
  int            checks    = 0;
  int            errors    = 0;

  rom_serial_dumper #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .start_addr           (start_addr),
    .word_count           (word_count),
    .busy                 (busy),
    .done                 (done),
    .rom_addr             (rom_addr),
    .rom_rd               (rom_rd),
    .rom_data             (rom_data),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom[rom_addr];
  end

  // UART: busy flag rises the cycle after an accepted transmit and stays
  // high for a random 1..4 cycles. Not affected by the DUT reset.
  always @(posedge clk) begin
    if (uart_busy_cnt != 0) begin
      uart_busy_cnt <= uart_busy_cnt - 1;
      if (uart_busy_cnt == 1) uart_is_transmitting <= 1'b0;
    end else if (uart_transmit) begin
      uart_is_transmitting <= 1'b1;
      uart_busy_cnt        <= int'($urandom_range(1, 4));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Byte monitor
  always @(negedge clk) begin
    if (uart_transmit) begin
      tx_seen++;
      chk("uart_idle_at_transmit", uart_is_transmitting, 1'b0);
      if (exp_bytes.size() == 0) begin
        fail_now("unexpected_byte");
      end else begin
        chk("tx_byte", uart_tx_byte, exp_bytes.pop_front());
      end
    end
  end

  // ROM address monitor
  always @(negedge clk) begin
    if (rom_rd) begin
      if (exp_addrs.size() == 0) begin
        fail_now("unexpected_rom_rd");
      end else begin
        chk("rom_addr", rom_addr, exp_addrs.pop_front());
      end
    end
  end

  // Done monitor
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      chk("busy_low_at_done", busy, 1'b0);
    end
  end

  // Reference model: the dump is the words rom[(sa+i) mod DEPTH] for i in
  // 0..n-1, each sent high byte then low byte, optionally followed by the
  // XOR of every byte sent.
  function automatic void expect_dump(input logic [AW-1:0] sa, input int n);
    logic [7:0]    ck = 8'h00;
    logic [15:0]   w;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(sa) + i) % DEPTH);
      w = rom[a];
      exp_addrs.push_back(a);
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[7:0]);
      ck = ck ^ w[15:8] ^ w[7:0];
    end
`ifdef ROM_DUMP_CHECKSUM_EN
    if (n > 0) exp_bytes.push_back(ck);
`endif
  endfunction

  // Holds start high across exactly one rising edge; returns at the
  // falling edge of the first cycle after the request was sampled.
  task automatic pulse_start(input logic [AW-1:0] sa, input int n);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    word_count = (AW + 1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int k = 0;
    while (done_seen == d0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_seen == d0) fail_now("done_timeout");
    repeat (4) @(negedge clk);
    chk("done_once", done_seen - d0, 1);
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("addrs_drained", exp_addrs.size(), 0);
  endtask

  task automatic wait_tx(input int target, input string name);
    int k = 0;
    while (tx_seen < target && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (tx_seen < target) fail_now(name);
  endtask

  task automatic run_dump(input logic [AW-1:0] sa, input int n, input bit lat);
    int d0 = done_seen;
    expect_dump(sa, n);
    pulse_start(sa, n);
    if (n != 0) chk("busy_after_start", busy, 1'b1);
    if (lat) begin
      chk("latency_rom_rd", rom_rd, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("latency_transmit", uart_transmit, 1'b1);
    end
    wait_done(d0, 40 + n * 30);
  endtask

  initial begin
    int d0;
    int t0;

    for (int i = 0; i < DEPTH; i++) rom[i] = 16'($urandom);
    rom[0]         = 16'h1234;
    rom[1]         = 16'hABCD;
    rom[DEPTH - 1] = 16'h5AA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rom_rd", rom_rd, 1'b0);
    chk("rst_rom_addr", rom_addr, '0);
    chk("rst_transmit", uart_transmit, 1'b0);
    chk("rst_tx_byte", uart_tx_byte, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Two known words, with latency check
    run_dump(15'h0000, 2, 1'b1);

    // Empty dump: done shortly after start, no transmit (byte monitor flags any)
    d0 = done_seen;
    expect_dump(15'h0010, 0);
    pulse_start(15'h0010, 0);
    chk("empty_done_cycle1", done, 1'b1);
    wait_done(d0, 3);

    // Address wrap at the top of the ROM
    run_dump(15'h7FFF, 2, 1'b0);

    // Second start during the second byte is ignored
    d0 = done_seen;
    t0 = tx_seen;
    expect_dump(15'h0000, 2);
    pulse_start(15'h0000, 2);
    wait_tx(t0 + 2, "second_byte_timeout");
    pulse_start(15'h0100, 5);
    wait_done(d0, 100);
    chk("ignored_start_bytes", tx_seen - t0, 4 + ((exp_bytes.size() == 0) ? 0 : 99)
`ifdef ROM_DUMP_CHECKSUM_EN
        + 1
`endif
        );

    // Reset in ACK_LO of word 0, then a clean dump
    d0 = done_seen;
    t0 = tx_seen;
    expect_dump(15'h0200, 3);
    pulse_start(15'h0200, 3);
    wait_tx(t0 + 2, "lo_byte_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_transmit", uart_transmit, 1'b0);
    rst = 1'b0;
    exp_bytes.delete();
    exp_addrs.delete();
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    run_dump(15'h0300, 2, 1'b0);

    // Randomized dumps
    for (int r = 0; r < 6; r++) begin
      run_dump(AW'($urandom), int'($urandom_range(1, 5)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_rom_serial_dumper
`default_nettype wire
